// File: rtl/miner_scheduler_if.sv
// Bundle between a mining host, the scheduler and its SHA-256 core.
// The master side is the host together with the hash core; the scheduler
// connects through the slave side.
interface miner_scheduler_if;
  logic         start;
  logic         abort;
  logic [407:0] prefix;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic [255:0] target;
  logic [511:0] sha_padded;
  logic         sha_enable;
  logic         sha_done;
  logic [255:0] sha_hashed;
  logic         busy;
  logic         found;
  logic         exhausted;
  logic         error;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic [31:0]  hash_count;

  modport master (
    output start, abort, prefix, nonce_start, nonce_end, target,
           sha_done, sha_hashed,
    input  sha_padded, sha_enable, busy, found, exhausted, error,
           found_nonce, found_hash, hash_count
  );

  modport slave (
    input  start, abort, prefix, nonce_start, nonce_end, target,
           sha_done, sha_hashed,
    output sha_padded, sha_enable, busy, found, exhausted, error,
           found_nonce, found_hash, hash_count
  );
endinterface

// File: rtl/miner_scheduler.sv
// Nonce-sweeping scheduler for a single-block SHA-256 core.
// Walks nonce_start..nonce_end (inclusive, wrapping through zero), launches
// one hash per nonce and stops on the first digest strictly below target,
// on range exhaustion, on a core timeout, or on abort.
module miner_scheduler #(
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  miner_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, CHECK, DRAIN, FOUND, EXHAUST, FAULT
  } state_t;

  localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT);

  state_t       r_state;
  logic [407:0] r_prefixQ;
  logic [31:0]  r_nonceQ;
  logic [31:0]  r_nonceEnd;
  logic [255:0] r_target;
  logic [255:0] r_hash;
  logic [31:0]  r_timer;
  logic [31:0]  r_hashCount;
  logic [31:0]  r_foundNonce;
  logic [255:0] r_foundHash;
  logic         r_shaEnable;
  logic         r_busy;
  logic         r_found;
  logic         r_exhausted;
  logic         r_error;

  // Message is 440 bits, so the padding marker and length always fit in one block.
  assign bus.sha_padded  = {r_prefixQ, r_nonceQ, 8'h80, 64'd440};
  assign bus.sha_enable  = r_shaEnable;
  assign bus.busy        = r_busy;
  assign bus.found       = r_found;
  assign bus.exhausted   = r_exhausted;
  assign bus.error       = r_error;
  assign bus.found_nonce = r_foundNonce;
  assign bus.found_hash  = r_foundHash;
  assign bus.hash_count  = r_hashCount;

  // Job sequencer: the nonce only advances in CHECK, after the digest for the
  // current block has been captured, so the block is stable for the whole hash.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_prefixQ    <= '0;
      r_nonceQ     <= '0;
      r_nonceEnd   <= '0;
      r_target     <= '0;
      r_hash       <= '0;
      r_timer      <= '0;
      r_hashCount  <= '0;
      r_foundNonce <= '0;
      r_foundHash  <= '0;
      r_shaEnable  <= 1'b0;
      r_busy       <= 1'b0;
      r_found      <= 1'b0;
      r_exhausted  <= 1'b0;
      r_error      <= 1'b0;
    end else if (bus.abort && r_state != IDLE) begin
      r_state     <= IDLE;
      r_shaEnable <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            r_prefixQ   <= bus.prefix;
            r_target    <= bus.target;
            r_nonceEnd  <= bus.nonce_end;
            r_nonceQ    <= bus.nonce_start;
            r_found     <= 1'b0;
            r_exhausted <= 1'b0;
            r_error     <= 1'b0;
            r_hashCount <= '0;
            r_busy      <= 1'b1;
            r_state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_shaEnable <= 1'b1;
          r_timer     <= '0;
          r_state     <= WAIT;
        end
        WAIT: begin
          if (bus.sha_done) begin
            r_hash      <= bus.sha_hashed;
            r_hashCount <= r_hashCount + 32'd1;
            r_shaEnable <= 1'b0;
            r_state     <= CHECK;
          end else begin
            r_timer <= r_timer + 32'd1;
            if (r_timer + 32'd1 == LP_TIMEOUT) begin
              r_shaEnable <= 1'b0;
              r_state     <= FAULT;
            end
          end
        end
        CHECK: begin
          if (r_hash < r_target) begin
            r_state <= FOUND;
          end else if (r_nonceQ == r_nonceEnd) begin
            r_state <= EXHAUST;
          end else begin
            r_nonceQ <= r_nonceQ + 32'd1;
            r_state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (!bus.sha_done) begin
            r_state <= LAUNCH;
          end
        end
        FOUND: begin
          r_found      <= 1'b1;
          r_foundNonce <= r_nonceQ;
          r_foundHash  <= r_hash;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        EXHAUST: begin
          r_exhausted <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        FAULT: begin
          r_error <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miner_scheduler.sv
// Scoreboard bench for miner_scheduler: a job model pushes the expected
// block per launch and the expected job result; monitors pop and compare.
module tb_miner_scheduler;

  typedef struct {
    logic         found;
    logic         exhausted;
    logic         error;
    logic [31:0]  nonce;
    logic [255:0] hash;
    logic [31:0]  count;
  } result_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  miner_scheduler_if bus();

  int compares   = 0;
  int mismatches = 0;

  logic [511:0] launchQ[$];
  result_t      resultQ[$];
  bit           coreNever     = 1'b0;
  int           coreHoldFixed = 0;

  miner_scheduler #(.TIMEOUT(255)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
    compares++;
    if (actual !== expected) begin
      mismatches++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input string what);
    compares++;
    mismatches++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  // Stand-in digest: any deterministic mix of prefix and nonce will do.
  function automatic logic [255:0] hashOf(input logic [407:0] p, input logic [31:0] n);
    logic [31:0] m;
    m = (n * 32'h9E3779B1) ^ 32'h5BD1E995;
    return {8{m}} ^ p[407:152];
  endfunction

  function automatic logic [407:0] randPrefix();
    logic [415:0] t;
    t = '0;
    for (int i = 0; i < 13; i++) t = {t[383:0], 32'($urandom)};
    return t[407:0];
  endfunction

  // Job-level reference: sweep the range, stop on first digest below target.
  task automatic modelJob(input logic [407:0] p, input logic [31:0] ns, input logic [31:0] ne,
                          input logic [255:0] tgt);
    logic [31:0] n;
    logic [31:0] cnt;
    result_t     r;
    n   = ns;
    cnt = '0;
    r   = '{default: '0};
    for (int guard = 0; guard < 64; guard++) begin
      launchQ.push_back({p, n, 8'h80, 64'd440});
      cnt++;
      if (hashOf(p, n) < tgt) begin
        r.found = 1'b1;
        r.nonce = n;
        r.hash  = hashOf(p, n);
        break;
      end
      if (n == ne) begin
        r.exhausted = 1'b1;
        break;
      end
      n++;
    end
    r.count = cnt;
    resultQ.push_back(r);
  endtask

  task automatic issueStart(input logic [407:0] p, input logic [31:0] ns, input logic [31:0] ne,
                            input logic [255:0] tgt);
    @(negedge clk);
    bus.prefix      = p;
    bus.nonce_start = ns;
    bus.nonce_end   = ne;
    bus.target      = tgt;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start       = 1'b0;
  endtask

  task automatic applyStimulus(input logic [407:0] p, input logic [31:0] ns, input logic [31:0] ne,
                               input logic [255:0] tgt);
    modelJob(p, ns, ne, tgt);
    issueStart(p, ns, ne, tgt);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) failNow("job completion", "busy still 1 after cycle budget, expected 0");
    @(negedge clk);
  endtask

  task automatic waitEnable(input logic level, input int budget);
    int n = 0;
    while (bus.sha_enable !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.sha_enable !== level) failNow("sha_enable wait", "level not reached within cycle budget");
  endtask

  // Hash core model: random latency, done held one or two cycles.
  initial begin
    int delay = 0;
    int hold  = 0;
    bit pending = 1'b0;
    bus.sha_done   = 1'b0;
    bus.sha_hashed = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pending      = 1'b0;
        hold         = 0;
        bus.sha_done = 1'b0;
      end else if (bus.sha_done) begin
        hold--;
        if (hold <= 0) bus.sha_done = 1'b0;
      end else if (pending) begin
        if (!bus.sha_enable) begin
          pending = 1'b0;
        end else begin
          delay--;
          if (delay == 0) begin
            pending        = 1'b0;
            bus.sha_hashed = hashOf(bus.sha_padded[511:104], bus.sha_padded[103:72]);
            bus.sha_done   = 1'b1;
            hold           = (coreHoldFixed > 0) ? coreHoldFixed : int'($urandom_range(1, 2));
          end
        end
      end else if (bus.sha_enable && !coreNever) begin
        pending = 1'b1;
        delay   = int'($urandom_range(1, 4));
      end
    end
  end

  // Monitor: every launch and every job end is checked against the queues.
  initial begin
    logic         prevEn   = 1'b0;
    logic         prevBusy = 1'b0;
    logic [511:0] expBlock = '0;
    result_t      r;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.sha_enable && !prevEn) begin
          if (launchQ.size() == 0) begin
            failNow("launch", $sformatf("got launch of block %0h, expected no launch", bus.sha_padded));
          end else begin
            expBlock = launchQ.pop_front();
            checkOutput("launch block", bus.sha_padded, expBlock);
          end
        end
        if (!bus.sha_enable && prevEn) checkOutput("block held to capture", bus.sha_padded, expBlock);
        if (!bus.busy && prevBusy) begin
          if (resultQ.size() == 0) begin
            failNow("job end", "got job end, expected no job running");
          end else begin
            r = resultQ.pop_front();
            checkOutput("result flags", 512'({bus.found, bus.exhausted, bus.error}),
                        512'({r.found, r.exhausted, r.error}));
            checkOutput("hash_count", 512'(bus.hash_count), 512'(r.count));
            if (r.found) begin
              checkOutput("found_nonce", 512'(bus.found_nonce), 512'(r.nonce));
              checkOutput("found_hash", 512'(bus.found_hash), 512'(r.hash));
            end
          end
        end
      end
      prevEn   = bus.sha_enable;
      prevBusy = bus.busy;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [407:0] p;
    logic [31:0]  ns;
    logic [31:0]  ne;
    logic [255:0] tgt;
    logic [407:0] tmp;
    result_t      r;
    int           hi;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.prefix = '0;
    bus.nonce_start = '0;
    bus.nonce_end = '0;
    bus.target = '0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("reset flags", 512'({bus.sha_enable, bus.busy, bus.found, bus.exhausted, bus.error}), 512'(0));
    checkOutput("reset counters", 512'({bus.hash_count, bus.found_nonce}), 512'(0));
    checkOutput("reset found_hash", 512'(bus.found_hash), 512'(0));
    checkOutput("reset block", bus.sha_padded, {440'd0, 8'h80, 64'd440});
    #2 rst = 1'b1;

    // Single nonce, everything below all-ones target
    p = randPrefix();
    applyStimulus(p, 32'd5, 32'd5, {256{1'b1}});
    waitIdle(200);
    checkOutput("single found", 512'({bus.found, bus.busy}), 512'(2'b10));
    checkOutput("single nonce", 512'(bus.found_nonce), 512'(32'd5));
    checkOutput("single count", 512'(bus.hash_count), 512'(32'd1));

    // Target zero: four launches then exhausted
    applyStimulus(randPrefix(), 32'd0, 32'd3, '0);
    waitIdle(300);
    checkOutput("range exhausted", 512'({bus.found, bus.exhausted, bus.hash_count}), 512'({2'b01, 32'd4}));

    // Range wrapping through zero
    applyStimulus(randPrefix(), 32'hFFFF_FFFE, 32'h0000_0001, '0);
    waitIdle(300);
    checkOutput("wrap exhausted", 512'({bus.exhausted, bus.hash_count}), 512'({1'b1, 32'd4}));

    // Digest exactly equal to target is not a hit
    p = randPrefix();
    applyStimulus(p, 32'd9, 32'd9, hashOf(p, 32'd9));
    waitIdle(200);
    checkOutput("equal not found", 512'({bus.found, bus.exhausted}), 512'(2'b01));

    // Core never answers: 255 cycles of waiting, then error
    coreNever = 1'b1;
    p = randPrefix();
    launchQ.push_back({p, 32'd3, 8'h80, 64'd440});
    r = '{default: '0};
    r.error = 1'b1;
    resultQ.push_back(r);
    issueStart(p, 32'd3, 32'd3, '0);
    waitEnable(1'b1, 20);
    hi = 0;
    while (bus.sha_enable && hi < 1000) begin
      hi++;
      @(negedge clk);
    end
    checkOutput("timeout wait length", 512'(hi), 512'(255));
    checkOutput("error before fault", 512'({bus.error, bus.busy}), 512'(2'b01));
    @(negedge clk);
    checkOutput("error after fault", 512'({bus.error, bus.busy}), 512'(2'b10));
    coreNever = 1'b0;
    @(negedge clk);

    // Abort while waiting on the second hash
    p = randPrefix();
    launchQ.push_back({p, 32'd0, 8'h80, 64'd440});
    launchQ.push_back({p, 32'd1, 8'h80, 64'd440});
    r = '{default: '0};
    r.count = 32'd1;
    resultQ.push_back(r);
    issueStart(p, 32'd0, 32'd5, '0);
    waitEnable(1'b1, 20);
    waitEnable(1'b0, 20);
    waitEnable(1'b1, 20);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abort outputs", 512'({bus.sha_enable, bus.busy, bus.found, bus.exhausted, bus.error}), 512'(0));
    checkOutput("abort count", 512'(bus.hash_count), 512'(32'd1));
    repeat (3) @(negedge clk);

    // Start together with abort in IDLE is ignored
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkOutput("start+abort ignored", 512'(bus.busy), 512'(0));
    repeat (3) @(negedge clk);

    // Reset mid-job, then a clean job with double-length done pulses
    applyStimulus(randPrefix(), 32'd0, 32'd3, '0);
    waitEnable(1'b1, 20);
    #2 rst = 1'b0;
    #1;
    checkOutput("async reset flags", 512'({bus.sha_enable, bus.busy, bus.found, bus.exhausted, bus.error}), 512'(0));
    checkOutput("async reset counts", 512'({bus.hash_count, bus.found_nonce}), 512'(0));
    checkOutput("async reset block", bus.sha_padded, {440'd0, 8'h80, 64'd440});
    launchQ.delete();
    resultQ.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("no launch after reset", 512'({bus.sha_enable, bus.busy}), 512'(0));
    coreHoldFixed = 2;
    applyStimulus(randPrefix(), 32'd7, 32'd7, '0);
    waitIdle(200);
    checkOutput("held done single count", 512'({bus.exhausted, bus.hash_count}), 512'({1'b1, 32'd1}));
    coreHoldFixed = 0;

    // Randomized jobs, sometimes with a stray start while busy
    for (int j = 0; j < 40; j++) begin
      p  = randPrefix();
      ns = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 4)) : 32'($urandom);
      ne = ns + 32'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0: tgt = '0;
        1: tgt = {256{1'b1}};
        2: begin tmp = randPrefix(); tgt = tmp[255:0]; end
        default: tgt = hashOf(p, ns);
      endcase
      applyStimulus(p, ns, ne, tgt);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        bus.prefix      = ~p;
        bus.nonce_start = 32'($urandom);
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start       = 1'b0;
      end
      waitIdle(500);
    end

    repeat (3) @(negedge clk);
    checkOutput("launches outstanding", 512'(launchQ.size()), 512'(0));
    checkOutput("results outstanding", 512'(resultQ.size()), 512'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule

// File: doc/miner_scheduler.md
MINER_SCHEDULER -- requirements
Module: miner_scheduler

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 255, the maximum number of cycles to wait for sha_done per hash before flagging an error.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 The module SHALL have port start, input, 1, a job request sampled only in IDLE.
REQ-005 The module SHALL have port abort, input, 1, which terminates the current job.
REQ-006 The module SHALL have port prefix, input, 408, the fixed message bytes preceding the nonce.
REQ-007 The module SHALL have ports nonce_start and nonce_end, input, 32 each, the inclusive nonce range.
REQ-008 The module SHALL have port target, input, 256, the unsigned success threshold.
REQ-009 The module SHALL have port sha_padded, output, 512, the single padded block to the hash core.
REQ-010 The module SHALL have port sha_enable, output, 1, the hash-core start request.
REQ-011 The module SHALL have ports sha_done (input, 1) and sha_hashed (input, 256), the hash-core completion flag and digest.
REQ-012 The module SHALL have port busy, output, 1, high while a job is active.
REQ-013 The module SHALL have ports found, exhausted and error, output, 1 each, sticky job-result flags.
REQ-014 The module SHALL have ports found_nonce (output, 32), found_hash (output, 256) and hash_count (output, 32).

Function
REQ-015 sha_padded SHALL equal {prefix_q, nonce_q, 8'h80, 64'd440}, where prefix_q and nonce_q are registered copies; this is fixed single-block padding for a 440-bit message.
REQ-016 States SHALL be IDLE, LAUNCH, WAIT, CHECK, DRAIN, FOUND, EXHAUST and FAULT.
REQ-017 In IDLE with start=1, the module SHALL latch prefix, target and nonce_end, load nonce_q=nonce_start, clear found/exhausted/error/hash_count, set busy=1 and go to LAUNCH next cycle.
REQ-018 LAUNCH SHALL assert sha_enable, clear the timeout counter and go to WAIT.
REQ-019 In WAIT, sha_enable SHALL stay high until the first cycle sha_done=1 is seen.
REQ-020 In that first sha_done=1 cycle, the module SHALL capture sha_hashed, increment hash_count (wrapping mod 2^32), drop sha_enable and go to CHECK.
REQ-021 In WAIT, the timeout counter SHALL increment each cycle; when it reaches TIMEOUT with sha_done=0, the module SHALL go to FAULT.
REQ-022 CHECK: if the captured hash < target (unsigned 256-bit), the module SHALL go to FOUND.
REQ-023 CHECK: else if nonce_q == nonce_end, the module SHALL go to EXHAUST.
REQ-024 CHECK: otherwise, the module SHALL set nonce_q = nonce_q+1 (mod 2^32; wrap FFFFFFFF->0 allowed) and go to DRAIN.
REQ-025 DRAIN SHALL hold until sha_done=0, then go to LAUNCH; sha_padded SHALL never change between LAUNCH and the capture cycle.
REQ-026 FOUND SHALL set found=1, found_nonce=nonce_q and found_hash=captured hash.
REQ-027 EXHAUST SHALL set exhausted=1; FAULT SHALL set error=1.
REQ-028 FOUND, EXHAUST and FAULT SHALL each clear busy and return to IDLE one cycle later.
REQ-029 Result flags SHALL remain set until the next accepted start or reset.
REQ-030 abort=1 in any non-IDLE state SHALL drop sha_enable and busy and return to IDLE next cycle without setting any flag; abort takes priority over all other transitions.
REQ-031 start while busy SHALL be ignored; start and abort together in IDLE SHALL be ignored.
REQ-032 Hash equal to target SHALL NOT count as found.

Reset
REQ-033 On rst=0, state SHALL become IDLE asynchronously and sha_enable, busy, found, exhausted and error SHALL be 0.
REQ-034 On rst=0, found_nonce, found_hash, hash_count, nonce_q and prefix_q SHALL be 0.
REQ-035 Reset mid-job SHALL discard the job; after reset release, no launch SHALL occur until a new start.

Verification
REQ-036 target=all-ones, nonce_start=nonce_end=5, start pulse -> found=1, found_nonce=5, hash_count=1, busy=0.
REQ-037 target=0, range 0..3 -> exactly 4 sha_enable launches with nonces 0,1,2,3 in order; exhausted=1, hash_count=4, found=0.
REQ-038 target=0, range FFFFFFFE..00000001 -> nonces FFFFFFFE, FFFFFFFF, 0, 1; exhausted=1, hash_count=4.
REQ-039 Core model never raises sha_done, TIMEOUT=255 -> error=1 exactly 255 cycles after LAUNCH's WAIT entry; busy=0.
REQ-040 abort in WAIT of the 2nd hash -> sha_enable=0 and busy=0 next cycle, all flags 0, hash_count=1.
REQ-041 rst=0 during WAIT -> all outputs 0 immediately; a new start with range 7..7 runs cleanly, with sha_done held 2 cycles per hash producing a single count.
